// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the FP16 datapath (adder and multiplier back ends).
//   - field widths and exponent constants of IEEE-754 binary16
//   - fp16_t        : packed {sign, exp, frac}
//   - norm_t        : normalised-but-unrounded intermediate carried between
//                     the normalise stage and the round/pack stage
//   - Inf / QNaN encodings and a small packing helper
// -----------------------------------------------------------------------------
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  localparam int GRS_W   = 3;

  // Internal exponent is two's complement so that underflow (<=0) and
  // overflow (>=31, up to 33 after a carry and a rounding bump) are visible.
  localparam int EXPI_W  = 7;
  localparam logic signed [EXPI_W-1:0] EXPI_SAT = EXPI_W'(EXP_MAX);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  localparam fp16_t FP16_POS_INF = '{sign: 1'b0, exp: 5'h1F, frac: 10'h000};
  localparam fp16_t FP16_NEG_INF = '{sign: 1'b1, exp: 5'h1F, frac: 10'h000};
  localparam fp16_t FP16_QNAN    = '{sign: 1'b0, exp: 5'h1F, frac: 10'h200};

  typedef struct packed {
    logic              sign;
    logic [EXPI_W-1:0] exp;   // interpreted as signed
    logic [FRAC_W-1:0] frac;
    logic              g;     // guard bit
    logic              s;     // sticky bit
    logic              zero;  // exact-zero difference
    logic              unf;   // exponent underflowed before rounding
  } norm_t;

  function automatic fp16_t fp16_pack(input logic              sign,
                                      input logic [EXP_W-1:0]  exp,
                                      input logic [FRAC_W-1:0] frac);
    fp16_t v;
    v.sign = sign;
    v.exp  = exp;
    v.frac = frac;
    return v;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// -----------------------------------------------------------------------------
// fp16_round_pack
// Combinational round-to-nearest-even, overflow saturation and packing of a
// normalised FP16 intermediate. Shared by the adder and multiplier paths.
// Ports:
//   i_sign, i_exp (signed), i_frac, i_g, i_s : normalised value + guard/sticky
//   i_zero, i_unf                            : special cases decided upstream
//   o_result                                 : packed FP16
//   o_ovf / o_unf / o_zero                   : mutually exclusive status flags
// Parameter ROUND_EN: 1 = round to nearest even, 0 = truncate.
// -----------------------------------------------------------------------------
module fp16_round_pack
  import fp16_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic              i_sign,
  input  logic [EXPI_W-1:0] i_exp,
  input  logic [FRAC_W-1:0] i_frac,
  input  logic              i_g,
  input  logic              i_s,
  input  logic              i_zero,
  input  logic              i_unf,
  output fp16_t             o_result,
  output logic              o_ovf,
  output logic              o_unf,
  output logic              o_zero
);

  logic                     w_rup;
  logic [FRAC_W:0]          w_frac_sum;
  logic signed [EXPI_W-1:0] w_exp_rnd;

  // Round up above the halfway point, or exactly at it when the LSB is odd.
  assign w_rup      = ROUND_EN & i_g & (i_s | i_frac[0]);
  assign w_frac_sum = {1'b0, i_frac} + {{FRAC_W{1'b0}}, w_rup};
  // A carry out of the fraction leaves frac=0 and bumps the exponent.
  assign w_exp_rnd  = $signed(i_exp) + $signed({{(EXPI_W-1){1'b0}}, w_frac_sum[FRAC_W]});

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    o_unf    = 1'b0;
    o_zero   = 1'b0;
    if (i_zero) begin
      o_zero = 1'b1;                       // +0, sign already dropped
    end else if (i_unf) begin
      o_unf         = 1'b1;
      o_result.sign = i_sign;              // signed zero, no subnormals
    end else if (w_exp_rnd >= EXPI_SAT) begin
      o_ovf    = 1'b1;
      o_result = i_sign ? FP16_NEG_INF : FP16_POS_INF;
    end else begin
      o_result = fp16_pack(i_sign, w_exp_rnd[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]);
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// -----------------------------------------------------------------------------
// fp16_norm_round
// Final stage of the FP16 adder: normalise (stage 1), round/pack (stage 2).
// Two-stage valid/ready pipeline, latency 2, throughput 1 per cycle.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : upstream handshake
//   sign, exp_l, op_sub       : result sign, larger exponent, effective subtract
//   sum_m, sub_m, lza_count   : aligned mantissa sum / difference, leading zeros
//   out_valid / out_ready     : downstream handshake
//   result                    : packed FP16
//   ovf, unf, zero            : status flags, meaningful only with out_valid
// -----------------------------------------------------------------------------
module fp16_norm_round
  import fp16_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [4:0]  exp_l,
  input  logic        op_sub,
  input  logic [14:0] sum_m,
  input  logic [13:0] sub_m,
  input  logic [3:0]  lza_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        zero
);

  logic        w_s1_en;
  logic        w_s2_en;
  logic [12:0] w_sub_sh;
  norm_t       w_norm;
  fp16_t       w_rp_result;
  logic        w_rp_ovf;
  logic        w_rp_unf;
  logic        w_rp_zero;

  logic        r_s1_valid;
  norm_t       r_s1;
  logic        r_out_valid;
  fp16_t       r_result;
  logic        r_ovf;
  logic        r_unf;
  logic        r_zero;

  // A stage may load when it is empty or its contents leave this cycle.
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  // Only the low 13 bits of the normalised difference are ever used: bit 13
  // is the hidden one after the shift, so shift sub_m[12:0] directly.
  assign w_sub_sh = sub_m[12:0] << lza_count;

  always_comb begin
    w_norm      = '0;
    w_norm.sign = sign;
    if (!op_sub) begin
      if (sum_m[14]) begin
        w_norm.frac = sum_m[13:4];
        w_norm.g    = sum_m[3];
        w_norm.s    = |sum_m[2:0];
        w_norm.exp  = {2'b00, exp_l} + 7'd1;
      end else begin
        w_norm.frac = sum_m[12:3];
        w_norm.g    = sum_m[2];
        w_norm.s    = |sum_m[1:0];
        w_norm.exp  = {2'b00, exp_l};
      end
    end else if (sub_m == '0) begin
      w_norm.zero = 1'b1;
      w_norm.sign = 1'b0;
    end else begin
      w_norm.frac = w_sub_sh[12:3];
      w_norm.g    = w_sub_sh[2];
      w_norm.s    = |w_sub_sh[1:0];
      w_norm.exp  = {2'b00, exp_l} - {3'b000, lza_count};
    end
    w_norm.unf = !w_norm.zero && ($signed(w_norm.exp) <= 7'sd0);
  end

  // Stage 1: normalise register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_norm;
      end
    end
  end

  fp16_round_pack #(
    .ROUND_EN (ROUND_EN)
  ) u_round_pack (
    .i_sign   (r_s1.sign),
    .i_exp    (r_s1.exp),
    .i_frac   (r_s1.frac),
    .i_g      (r_s1.g),
    .i_s      (r_s1.s),
    .i_zero   (r_s1.zero),
    .i_unf    (r_s1.unf),
    .o_result (w_rp_result),
    .o_ovf    (w_rp_ovf),
    .o_unf    (w_rp_unf),
    .o_zero   (w_rp_zero)
  );

  // Stage 2: round/pack register, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_rp_result;
        r_ovf    <= w_rp_ovf;
        r_unf    <= w_rp_unf;
        r_zero   <= w_rp_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign zero      = r_zero;

endmodule
